// File: rtl/riscv_pkg.sv
// riscv_pkg: shared datapath widths and write-back select encoding
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int RA_W = 5;
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2
  } wb_sel_e;
endpackage

// File: rtl/pipe_reg.sv
// pipe_reg: W-bit register (clk, reset active-low async, en load, clr sync clear over en, d -> q)
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/mem_wb_pipe_reg.sv
// mem_wb_pipe_reg: MEM/WB register (stall holds, flush bubbles) driving *_out copies plus wb_data_out/wb_en_out
module mem_wb_pipe_reg
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int RA_W = riscv_pkg::RA_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            valid_in,
  input  logic [XLEN-1:0] mem_data_in,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] pc_plus4_in,
  input  logic [RA_W-1:0] rd_in,
  input  logic            reg_write_in,
  input  logic            mem_to_reg_in,
  input  logic            link_in,
  output logic            valid_out,
  output logic [XLEN-1:0] mem_data_out,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] pc_plus4_out,
  output logic [RA_W-1:0] rd_out,
  output logic            reg_write_out,
  output logic            mem_to_reg_out,
  output logic            link_out,
  output logic [XLEN-1:0] wb_data_out,
  output logic            wb_en_out
);
  localparam int W = 3 * XLEN + RA_W + 4;
  logic [W-1:0] q;
  wb_sel_e wb_sel;
  pipe_reg #(.W(W)) u_reg (
    .clk  (clk),
    .reset(reset),
    .en   (~stall),
    .clr  (flush),
    .d    ({valid_in, mem_data_in, alu_result_in, pc_plus4_in, rd_in,
            reg_write_in, mem_to_reg_in, link_in}),
    .q    (q)
  );
  assign {valid_out, mem_data_out, alu_result_out, pc_plus4_out, rd_out,
          reg_write_out, mem_to_reg_out, link_out} = q;
  assign wb_sel = link_out ? WB_LINK : mem_to_reg_out ? WB_MEM : WB_ALU;
  assign wb_data_out = wb_sel == WB_LINK ? pc_plus4_out :
                       wb_sel == WB_MEM  ? mem_data_out : alu_result_out;
  assign wb_en_out = valid_out & reg_write_out & |rd_out;
endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// tb_mem_wb_pipe_reg: directed checks of load, wb mux, x0 gating, stall, flush and async reset
module tb_mem_wb_pipe_reg;
  logic        clk = 1'b0;
  logic        reset, stall, flush, valid_in, reg_write_in, mem_to_reg_in, link_in;
  logic [31:0] mem_data_in, alu_result_in, pc_plus4_in;
  logic [4:0]  rd_in;
  logic        valid_out, reg_write_out, mem_to_reg_out, link_out, wb_en_out;
  logic [31:0] mem_data_out, alu_result_out, pc_plus4_out, wb_data_out;
  logic [4:0]  rd_out;
  int checks = 0;
  int errors = 0;

  mem_wb_pipe_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .mem_data_in(mem_data_in), .alu_result_in(alu_result_in), .pc_plus4_in(pc_plus4_in),
    .rd_in(rd_in), .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .link_in(link_in), .valid_out(valid_out), .mem_data_out(mem_data_out),
    .alu_result_out(alu_result_out), .pc_plus4_out(pc_plus4_out), .rd_out(rd_out),
    .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out), .link_out(link_out),
    .wb_data_out(wb_data_out), .wb_en_out(wb_en_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic v, input logic [31:0] md,
                            input logic [31:0] alu, input logic [31:0] pc4, input logic [4:0] rd,
                            input logic rw, input logic m2r, input logic lk,
                            input logic [31:0] wbd, input logic wben);
    chk({tag, ".valid"}, 32'(valid_out), 32'(v));
    chk({tag, ".mem_data"}, mem_data_out, md);
    chk({tag, ".alu"}, alu_result_out, alu);
    chk({tag, ".pc4"}, pc_plus4_out, pc4);
    chk({tag, ".rd"}, 32'(rd_out), 32'(rd));
    chk({tag, ".reg_write"}, 32'(reg_write_out), 32'(rw));
    chk({tag, ".mem_to_reg"}, 32'(mem_to_reg_out), 32'(m2r));
    chk({tag, ".link"}, 32'(link_out), 32'(lk));
    chk({tag, ".wb_data"}, wb_data_out, wbd);
    chk({tag, ".wb_en"}, 32'(wb_en_out), 32'(wben));
  endtask

  task automatic drive(input logic v, input logic [31:0] md, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [4:0] rd,
                       input logic rw, input logic m2r, input logic lk);
    valid_in = v; mem_data_in = md; alu_result_in = alu; pc_plus4_in = pc4;
    rd_in = rd; reg_write_in = rw; mem_to_reg_in = m2r; link_in = lk;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1, 32'hFFFF_FFFF, 32'h1111_1111, 32'h2222_2222, 5'd31, 1, 1, 1);
    step(); step();
    expect_all("reset_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    drive(1, 32'hABCD_1234, 32'hDEAD_BEEF, 32'h0000_0100, 5'd10, 1, 1, 0);
    step();
    expect_all("load_mem", 1, 32'hABCD_1234, 32'hDEAD_BEEF, 32'h0000_0100, 10, 1, 1, 0,
               32'hABCD_1234, 1);
    drive(1, 32'hCAFE_BABE, 32'h1234_5678, 32'h0000_0100, 5'd5, 1, 0, 0);
    step();
    expect_all("load_alu", 1, 32'hCAFE_BABE, 32'h1234_5678, 32'h0000_0100, 5, 1, 0, 0,
               32'h1234_5678, 1);
    drive(1, 32'hCAFE_BABE, 32'h1234_5678, 32'h0000_0104, 5'd1, 1, 1, 1);
    step();
    expect_all("link_pri", 1, 32'hCAFE_BABE, 32'h1234_5678, 32'h0000_0104, 1, 1, 1, 1,
               32'h0000_0104, 1);
    drive(1, 32'h0, 32'h5555_AAAA, 32'h0000_0108, 5'd0, 1, 0, 0);
    step();
    expect_all("x0", 1, 32'h0, 32'h5555_AAAA, 32'h0000_0108, 0, 1, 0, 0, 32'h5555_AAAA, 0);
    drive(1, 32'h7777_0000, 32'h0BAD_F00D, 32'h0000_010C, 5'd7, 0, 1, 0);
    step();
    expect_all("no_rw", 1, 32'h7777_0000, 32'h0BAD_F00D, 32'h0000_010C, 7, 0, 1, 0,
               32'h7777_0000, 0);
    drive(0, 32'h0, 32'h0000_0042, 32'h0000_0110, 5'd8, 1, 0, 0);
    step();
    expect_all("invalid", 0, 32'h0, 32'h0000_0042, 32'h0000_0110, 8, 1, 0, 0, 32'h0000_0042, 0);
    drive(1, 32'h0, 32'h1111_1111, 32'h0000_0200, 5'd9, 1, 0, 0);
    step();
    expect_all("pre_stall", 1, 32'h0, 32'h1111_1111, 32'h0000_0200, 9, 1, 0, 0,
               32'h1111_1111, 1);
    stall = 1'b1;
    drive(0, 32'hAAAA_0001, 32'hBBBB_0001, 32'h0000_0300, 5'd3, 0, 1, 1);
    step();
    expect_all("stall1", 1, 32'h0, 32'h1111_1111, 32'h0000_0200, 9, 1, 0, 0, 32'h1111_1111, 1);
    drive(1, 32'hAAAA_0002, 32'hBBBB_0002, 32'h0000_0304, 5'd4, 1, 1, 0);
    step();
    expect_all("stall2", 1, 32'h0, 32'h1111_1111, 32'h0000_0200, 9, 1, 0, 0, 32'h1111_1111, 1);
    drive(1, 32'hAAAA_0003, 32'hBBBB_0003, 32'h0000_0308, 5'd6, 1, 1, 0);
    step();
    expect_all("stall3", 1, 32'h0, 32'h1111_1111, 32'h0000_0200, 9, 1, 0, 0, 32'h1111_1111, 1);
    stall = 1'b0;
    step();
    expect_all("unstall", 1, 32'hAAAA_0003, 32'hBBBB_0003, 32'h0000_0308, 6, 1, 1, 0,
               32'hAAAA_0003, 1);
    flush = 1'b1;
    step();
    expect_all("flush", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 32'hAAAA_0003, 32'hBBBB_0003, 32'h0000_0308, 5'd6, 1, 1, 0);
    flush = 1'b0;
    step();
    expect_all("reload", 1, 32'hAAAA_0003, 32'hBBBB_0003, 32'h0000_0308, 6, 1, 1, 0,
               32'hAAAA_0003, 1);
    flush = 1'b1; stall = 1'b1;
    step();
    expect_all("flush_stall", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    flush = 1'b0;
    step();
    expect_all("after_bubble_stall", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stall = 1'b0;
    drive(1, 32'h0, 32'h0000_00FF, 32'h0000_0400, 5'd12, 1, 0, 1);
    step();
    expect_all("resume", 1, 32'h0, 32'h0000_00FF, 32'h0000_0400, 12, 1, 0, 1, 32'h0000_0400, 1);
    #2;
    reset = 1'b0;
    #1;
    expect_all("async_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    drive(1, 32'h1357_9BDF, 32'h2468_ACE0, 32'h0000_0500, 5'd15, 1, 1, 0);
    step();
    expect_all("post_reset", 1, 32'h1357_9BDF, 32'h2468_ACE0, 32'h0000_0500, 15, 1, 1, 0,
               32'h1357_9BDF, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
